// File: rtl/truth_table_capture.sv
// Sweeps every input vector onto a boolean block, captures its output and grades it.
// Optional early abort on first mismatch: define TT_CAPTURE_EARLY_ABORT_EN.
module truth_table_capture #(
  parameter  int NUM_IN = 3,
  parameter  int SETTLE = 2,
  localparam int TT_W   = 2**NUM_IN,
  parameter  logic [TT_W-1:0] EXPECTED = 8'hED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              f_in,
  output logic [NUM_IN-1:0] w_out,
  output logic              busy,
  output logic              done,
  output logic [TT_W-1:0]   table_out,
  output logic              pass,
  output logic [NUM_IN-1:0] fail_idx
);

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    SAMPLE,
    FINISH
  } state_t;

  // APPLY covers SETTLE cycles; SAMPLE adds the final cycle of the hold.
  localparam logic [3:0] RELOAD = 4'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam state_t     FIRST  = (SETTLE == 0) ? SAMPLE : APPLY;
  localparam logic [NUM_IN-1:0] LAST_IDX = NUM_IN'(TT_W - 1);

  state_t            state;
  logic [NUM_IN-1:0] idx;
  logic [3:0]        cnt;

  logic [TT_W-1:0]   tbl_next;
  logic [NUM_IN-1:0] first_bad;
  logic              tbl_ok;
  logic              last;
  logic              abort;

  always_comb begin
    tbl_next      = table_out;
    tbl_next[idx] = f_in;
  end

  // Scan downward so the lowest mismatching index wins.
  always_comb begin
    first_bad = '0;
    for (int i = TT_W - 1; i >= 0; i--) begin
      if (tbl_next[i] != EXPECTED[i]) begin
        first_bad = NUM_IN'(i);
      end
    end
  end

  assign tbl_ok = (tbl_next == EXPECTED);
  assign last   = (idx == LAST_IDX);

`ifdef TT_CAPTURE_EARLY_ABORT_EN
  assign abort = (f_in != EXPECTED[idx]);
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      w_out     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      table_out <= '0;
      pass      <= 1'b0;
      fail_idx  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done  <= 1'b0;
          w_out <= '0;
          if (start) begin
            state     <= FIRST;
            busy      <= 1'b1;
            idx       <= '0;
            cnt       <= RELOAD;
            table_out <= '0;
            pass      <= 1'b0;
            fail_idx  <= '0;
          end
        end
        APPLY: begin
          if (cnt == 4'd0) begin
            state <= SAMPLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        SAMPLE: begin
          table_out <= tbl_next;
          if (last || abort) begin
            state    <= FINISH;
            busy     <= 1'b0;
            done     <= 1'b1;
            w_out    <= '0;
            pass     <= tbl_ok;
            fail_idx <= tbl_ok ? '0 : first_bad;
          end else begin
            state <= FIRST;
            idx   <= idx + 1'b1;
            w_out <= idx + 1'b1;
            cnt   <= RELOAD;
          end
        end
        FINISH: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_capture.sv
// Directed bench for truth_table_capture: golden, faulty, reset,
// restart and zero-settle sweeps.
module tb_truth_table_capture;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       start  = 1'b0;
  logic       start2 = 1'b0;
  logic       fault  = 1'b0;
  logic       f;
  logic       f2;

  logic [2:0] w;
  logic       busy;
  logic       done;
  logic [7:0] tbl;
  logic       pass;
  logic [2:0] fidx;

  logic [1:0] w2;
  logic       busy2;
  logic       done2;
  logic [3:0] tbl2;
  logic       pass2;
  logic [1:0] fidx2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // f = w1'w3' + w1w3 + w2w3 + w1w2 with w = {w1,w2,w3}
  always_comb begin
    f = (!w[2] && !w[0]) || (w[2] && w[0]) ||
        (w[1] && w[0]) || (w[2] && w[1]);
    if (fault && w == 3'd2) f = 1'b0;
  end

  assign f2 = w2[1] & w2[0];

  truth_table_capture u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .f_in      (f),
    .w_out     (w),
    .busy      (busy),
    .done      (done),
    .table_out (tbl),
    .pass      (pass),
    .fail_idx  (fidx)
  );

  truth_table_capture #(
    .NUM_IN   (2),
    .SETTLE   (0),
    .EXPECTED (4'h8)
  ) u_and (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start2),
    .f_in      (f2),
    .w_out     (w2),
    .busy      (busy2),
    .done      (done2),
    .table_out (tbl2),
    .pass      (pass2),
    .fail_idx  (fidx2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic sweep(input logic       flt,
                       input logic       extra,
                       input int         exp_n,
                       input logic [7:0] exp_t,
                       input logic       exp_p,
                       input logic [2:0] exp_i);
    int n    = 0;
    int wbad = 0;
    fault = flt;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("busy_rise", 32'(busy), 32'd1);
    chk("w_first", 32'(w), 32'd0);
    while (busy && n < 200) begin
      if (w !== 3'(n / 3)) wbad++;
      if (done) wbad++;
      start = extra && (n == 4 || n == 17);
      n++;
      tick;
    end
    start = 1'b0;
    chk("w_steps", 32'(wbad), 32'd0);
    chk("busy_cycles", 32'(n), 32'(exp_n));
    chk("done", 32'(done), 32'd1);
    chk("table", 32'(tbl), 32'(exp_t));
    chk("pass", 32'(pass), 32'(exp_p));
    chk("fail_idx", 32'(fidx), 32'(exp_i));
    tick;
    chk("done_pulse", 32'({busy, done}), 32'd0);
    chk("w_idle", 32'(w), 32'd0);
  endtask

  initial begin
    int k;
    int wbad;

    #12;
    chk("reset_vals", 32'({w, busy, done, tbl, pass, fidx}), 32'd0);
    chk("reset_vals2", 32'({w2, busy2, done2, tbl2, pass2, fidx2}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    tick;
    chk("idle_quiet", 32'({busy, done, w}), 32'd0);

    sweep(1'b0, 1'b0, 24, 8'hED, 1'b1, 3'd0);
    repeat (3) tick;
    chk("hold_table", 32'(tbl), 32'hED);
    chk("hold_pass", 32'(pass), 32'd1);

`ifdef TT_CAPTURE_EARLY_ABORT_EN
    sweep(1'b1, 1'b0, 9, 8'h01, 1'b0, 3'd2);
`else
    sweep(1'b1, 1'b0, 24, 8'hE9, 1'b0, 3'd2);
`endif
    fault = 1'b0;

    sweep(1'b0, 1'b1, 24, 8'hED, 1'b1, 3'd0);

    // start held high across the end of a sweep
    start = 1'b1;
    tick;
    k = 0;
    while (!done && k < 100) begin
      k++;
      tick;
    end
    chk("held_done", 32'(done), 32'd1);
    chk("held_len", 32'(k), 32'd24);
    tick;
    chk("held_idle", 32'({busy, done}), 32'd0);
    tick;
    chk("held_rerun", 32'(busy), 32'd1);
    chk("held_w", 32'(w), 32'd0);
    start = 1'b0;
    k = 0;
    while (!done && k < 100) begin
      k++;
      tick;
    end
    chk("held_done2", 32'(done), 32'd1);
    tick;

    // reset in busy cycle 10
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (9) tick;
    chk("mid_busy", 32'({busy, tbl}), 32'h105);
    rst_n = 1'b0;
    #1;
    chk("rst_mid", 32'({w, busy, done, tbl, pass, fidx}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) tick;
    chk("post_rst_idle", 32'({busy, done, w, tbl}), 32'd0);

    // zero settle, AND gate
    start2 = 1'b1;
    tick;
    start2 = 1'b0;
    chk("z_busy_rise", 32'(busy2), 32'd1);
    k = 0;
    wbad = 0;
    while (busy2 && k < 50) begin
      if (w2 !== 2'(k)) wbad++;
      k++;
      tick;
    end
    chk("z_w_steps", 32'(wbad), 32'd0);
    chk("z_busy_cycles", 32'(k), 32'd4);
    chk("z_done", 32'(done2), 32'd1);
    chk("z_table", 32'(tbl2), 32'h8);
    chk("z_pass", 32'(pass2), 32'd1);
    chk("z_fail_idx", 32'(fidx2), 32'd0);
    tick;
    chk("z_done_pulse", 32'({busy2, done2}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
